// File: rtl/rbm_sampler.sv
// rbm_sampler: stochastic activation / sampling stage behind rbm_core.
// Captures one partial-sum vector, evaluates a piecewise-linear sigmoid per
// neuron (one per cycle) and emits a binary state against an LFSR draw.
// Optional build macro: RBM_SAMPLER_DETERMINISTIC_EN replaces the random
// comparison with a fixed threshold at one half and removes the LFSR.

// Piecewise-linear sigmoid plus probability conversion for one neuron.
module rbm_sampler_plan #(
    parameter int BW_PS   = 16,
    parameter int FRAC    = 8,
    parameter int BW_RAND = 8
) (
    input  logic signed [BW_PS-1:0]   x,
    output logic        [BW_RAND-1:0] p
);
    // f is carried with FRAC+5 fractional bits so a/32 and 27/32 are exact
    localparam int FW = BW_PS + FRAC + 8;
    localparam int PW = FW + BW_RAND;
    localparam int FB = FRAC + 5;

    logic [BW_PS-1:0]   a;
    logic [FW-1:0]      ax;
    logic [FW-1:0]      f;
    logic [PW-1:0]      prod;
    logic [BW_RAND-1:0] pp;

    // |x| with saturation, segment select, scale to BW_RAND bits, fold sign
    always_comb begin
        if (x == {1'b1, {(BW_PS-1){1'b0}}})
            a = {1'b0, {(BW_PS-1){1'b1}}};
        else if (x[BW_PS-1])
            a = BW_PS'(-x);
        else
            a = BW_PS'(x);

        ax = FW'(a);
        if (ax >= (FW'(5) << FRAC))
            f = FW'(32) << FRAC;
        else if (ax >= (FW'(19) << (FRAC-3)))
            f = ax + (FW'(27) << FRAC);
        else if (ax >= (FW'(1) << FRAC))
            f = (ax << 2) + (FW'(20) << FRAC);
        else
            f = (ax << 3) + (FW'(16) << FRAC);

        prod = (PW'(f) << BW_RAND) >> FB;
        if (prod >= (PW'(1) << BW_RAND))
            pp = '1;
        else
            pp = prod[BW_RAND-1:0];

        // (2^BW_RAND - 1) - pp is just the bitwise complement
        p = x[BW_PS-1] ? ~pp : pp;
    end
endmodule

module rbm_sampler #(
    parameter int          NUM_N   = 3,
    parameter int          BW_PS   = 16,
    parameter int          FRAC    = 8,
    parameter int          BW_RAND = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     done_in,
    input  logic [BW_PS*NUM_N-1:0]   ps_in,
    output logic                     receive,
    output logic [NUM_N-1:0]         new_states,
    output logic [NUM_N-1:0]         new_states_en,
    output logic                     sample_done,
    output logic [BW_RAND-1:0]       dbg_prob
);
    localparam int IW = (NUM_N > 1) ? $clog2(NUM_N) : 1;

    typedef enum logic {IDLE, SAMPLE} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     armed_q, armed_d;
    logic [BW_PS*NUM_N-1:0]   ps_q, ps_d;

    logic                     rcv_d, sd_d;
    logic [NUM_N-1:0]         ns_d, nse_d;
    logic [BW_RAND-1:0]       prob_d;

    logic signed [BW_PS-1:0]  cur_x;
    logic [BW_RAND-1:0]       cur_p;
    logic                     sample_bit;
    logic [NUM_N-1:0]         onehot;

    assign cur_x  = ps_q[int'(idx_q)*BW_PS +: BW_PS];
    assign onehot = NUM_N'(1) << idx_q;

    rbm_sampler_plan #(.BW_PS(BW_PS), .FRAC(FRAC), .BW_RAND(BW_RAND)) u_plan (
        .x (cur_x),
        .p (cur_p)
    );

`ifdef RBM_SAMPLER_DETERMINISTIC_EN
    assign sample_bit = (cur_p >= (BW_RAND'(1) << (BW_RAND-1)));
`else
    logic [15:0] lfsr_q;

    // Galois LFSR, right shift; runs whenever the block is enabled
    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= SEED;
        else if (en)
            lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    assign sample_bit = (lfsr_q[BW_RAND-1:0] < cur_p);
`endif

    // next-state and next-output logic; outputs default to idle values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        armed_d = armed_q;
        ps_d    = ps_q;
        rcv_d   = 1'b0;
        sd_d    = 1'b0;
        ns_d    = '0;
        nse_d   = '0;
        prob_d  = dbg_prob;
        if (en) begin
            // a low done_in re-arms capture in either state
            if (!done_in)
                armed_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (done_in && armed_q) begin
                        ps_d    = ps_in;
                        armed_d = 1'b0;
                        rcv_d   = 1'b1;
                        idx_d   = '0;
                        state_d = SAMPLE;
                    end
                end
                SAMPLE: begin
                    nse_d  = onehot;
                    ns_d   = sample_bit ? onehot : '0;
                    prob_d = cur_p;
                    if (idx_q == IW'(NUM_N-1)) begin
                        sd_d    = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            armed_q       <= 1'b0;
            ps_q          <= '0;
            receive       <= 1'b0;
            new_states    <= '0;
            new_states_en <= '0;
            sample_done   <= 1'b0;
            dbg_prob      <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            armed_q       <= armed_d;
            ps_q          <= ps_d;
            receive       <= rcv_d;
            new_states    <= ns_d;
            new_states_en <= nse_d;
            sample_done   <= sd_d;
            dbg_prob      <= prob_d;
        end
    end
endmodule
